// File: rtl/easyaxi_slv_rd.sv
// easyaxi_slv_rd: AXI read slave that queues AR requests and returns R bursts in acceptance
// order, with each beat's data equal to its own address (DECERR/SLVERR beats return zero).
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_slv_rd #(
  parameter int OST_DEPTH = 8,
  parameter int MEM_BYTES = 'h1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     axi_slv_arvalid,
  output logic                     axi_slv_arready,
  input  logic [`AXI_ID_W-1:0]     axi_slv_arid,
  input  logic [`AXI_ADDR_W-1:0]   axi_slv_araddr,
  input  logic [`AXI_LEN_W-1:0]    axi_slv_arlen,
  input  logic [`AXI_SIZE_W-1:0]   axi_slv_arsize,
  input  logic [`AXI_BURST_W-1:0]  axi_slv_arburst,
  output logic                     axi_slv_rvalid,
  input  logic                     axi_slv_rready,
  output logic [`AXI_ID_W-1:0]     axi_slv_rid,
  output logic [`AXI_DATA_W-1:0]   axi_slv_rdata,
  output logic [`AXI_RESP_W-1:0]   axi_slv_rresp,
  output logic                     axi_slv_rlast,
  output logic                     slv_busy
);

  localparam int AW    = `AXI_ADDR_W;
  localparam int LW    = `AXI_LEN_W;
  localparam int SW    = `AXI_SIZE_W;
  localparam int PTR_W = $clog2(OST_DEPTH);
  localparam int ENT_W = `AXI_ID_W + AW + LW + SW + `AXI_BURST_W;

  localparam logic [0:0]            ST_IDLE      = 1'b0;
  localparam logic [0:0]            ST_BURST     = 1'b1;
  localparam logic [1:0]            BURST_FIXED  = 2'b00;
  localparam logic [1:0]            BURST_INCR   = 2'b01;
  localparam logic [1:0]            BURST_WRAP   = 2'b10;
  localparam logic [1:0]            BURST_RSV    = 2'b11;
  localparam logic [1:0]            RESP_OKAY    = 2'b00;
  localparam logic [1:0]            RESP_SLVERR  = 2'b10;
  localparam logic [1:0]            RESP_DECERR  = 2'b11;
  localparam logic [AW-1:0]         ADDR_ONE     = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]         MEM_LIMIT    = AW'(MEM_BYTES);
  localparam logic [LW-1:0]         LEN_ONE      = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]         SIZE_MAX     = SW'($clog2(`AXI_DATA_W / 8));
  localparam logic [PTR_W:0]        CNT_FULL     = (PTR_W+1)'(OST_DEPTH);
  localparam logic [PTR_W:0]        CNT_ONE      = {{PTR_W{1'b0}}, 1'b1};

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [SW-1:0] size,
                                              input logic [LW-1:0] len, input logic [1:0] mode);
    logic [AW-1:0] bytes;
    logic [AW-1:0] wrap_sz;
    logic [AW-1:0] nxt;
    bytes   = ADDR_ONE << size;
    wrap_sz = bytes * ({{(AW-LW){1'b0}}, len} + ADDR_ONE);
    case (mode)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (addr & ~(wrap_sz - ADDR_ONE)) | ((addr + bytes) & (wrap_sz - ADDR_ONE));
      default:     nxt = (addr & ~(bytes - ADDR_ONE)) + bytes;
    endcase
    return nxt;
  endfunction

  function automatic logic wrap_len_ok(input logic [LW-1:0] len);
    return (len == LW'(1)) || (len == LW'(3)) || (len == LW'(7)) || (len == LW'(15));
  endfunction

  // Reserved bursts walk as FIXED, WRAP with an illegal length walks as INCR.
  function automatic logic [1:0] walk_mode(input logic [1:0] burst, input logic [LW-1:0] len);
    logic [1:0] mode;
    case (burst)
      BURST_RSV:  mode = BURST_FIXED;
      BURST_WRAP: mode = wrap_len_ok(len) ? BURST_WRAP : BURST_INCR;
      default:    mode = burst;
    endcase
    return mode;
  endfunction

  function automatic logic burst_err(input logic [AW-1:0] addr, input logic [SW-1:0] size,
                                     input logic [LW-1:0] len, input logic [1:0] burst);
    logic [AW-1:0] bytes;
    bytes = ADDR_ONE << size;
    return (size > SIZE_MAX) || (burst == BURST_RSV) ||
           ((burst == BURST_WRAP) && (!wrap_len_ok(len) || ((addr & (bytes - ADDR_ONE)) != '0)));
  endfunction

  logic [ENT_W-1:0]          q_mem_r [OST_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]            q_cnt_r, q_cnt_nxt_s;
  logic                      arready_r, busy_r;
  logic [0:0]                state_r, state_nxt_s;
  logic [`AXI_ID_W-1:0]      cur_id_r;
  logic [LW-1:0]             cur_len_r, beat_cnt_r;
  logic [SW-1:0]             cur_size_r;
  logic [1:0]                cur_mode_r;
  logic                      cur_err_r;
  logic [AW-1:0]             beat_addr_r;
  logic                      rvalid_r, rlast_r;
  logic [`AXI_ID_W-1:0]      rid_r;
  logic [`AXI_DATA_W-1:0]    rdata_r;
  logic [`AXI_RESP_W-1:0]    rresp_r;

  logic                      push_s, pop_s, adv_s, go_idle_s, hs_s, empty_s;
  logic [`AXI_ID_W-1:0]      head_id_s, src_id_s;
  logic [AW-1:0]             head_addr_s, src_addr_s;
  logic [LW-1:0]             head_len_s, src_len_s, src_cnt_s;
  logic [SW-1:0]             head_size_s, src_size_s;
  logic [1:0]                head_burst_s, src_mode_s;
  logic                      src_err_s;
  logic [`AXI_DATA_W-1:0]    data_s;
  logic [`AXI_RESP_W-1:0]    resp_s;

  assign {head_id_s, head_addr_s, head_len_s, head_size_s, head_burst_s} = q_mem_r[rd_ptr_r];

  // Handshake decode, next state and source of the next beat (fresh head or walked address).
  always_comb begin
    push_s    = axi_slv_arvalid & arready_r;
    empty_s   = (q_cnt_r == '0);
    hs_s      = rvalid_r & axi_slv_rready;
    pop_s     = 1'b0;
    adv_s     = 1'b0;
    go_idle_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) pop_s = 1'b1;
        else          pop_s = 1'b0;
      end
      ST_BURST: begin
        if (hs_s && rlast_r) begin
          if (!empty_s) pop_s = 1'b1;
          else          go_idle_s = 1'b1;
        end else if (hs_s) begin
          adv_s = 1'b1;
        end else begin
          adv_s = 1'b0;
        end
      end
      default: go_idle_s = 1'b1;
    endcase
    q_cnt_nxt_s = q_cnt_r + (push_s ? CNT_ONE : '0) - (pop_s ? CNT_ONE : '0);
    if (pop_s)          state_nxt_s = ST_BURST;
    else if (go_idle_s) state_nxt_s = ST_IDLE;
    else                state_nxt_s = state_r;

    if (pop_s) begin
      src_id_s   = head_id_s;
      src_addr_s = head_addr_s;
      src_len_s  = head_len_s;
      src_size_s = head_size_s;
      src_mode_s = walk_mode(head_burst_s, head_len_s);
      src_err_s  = burst_err(head_addr_s, head_size_s, head_len_s, head_burst_s);
      src_cnt_s  = '0;
    end else begin
      src_id_s   = cur_id_r;
      src_addr_s = next_addr(beat_addr_r, cur_size_r, cur_len_r, cur_mode_r);
      src_len_s  = cur_len_r;
      src_size_s = cur_size_r;
      src_mode_s = cur_mode_r;
      src_err_s  = cur_err_r;
      src_cnt_s  = beat_cnt_r + LEN_ONE;
    end

    if (src_addr_s >= MEM_LIMIT) begin
      resp_s = RESP_DECERR;
      data_s = '0;
    end else if (src_err_s) begin
      resp_s = RESP_SLVERR;
      data_s = '0;
    end else begin
      resp_s = RESP_OKAY;
      data_s = `AXI_DATA_W'(src_addr_s);
    end
  end

  // Queue storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) q_mem_r[wr_ptr_r] <= {axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
                                      axi_slv_arsize, axi_slv_arburst};
  end

  // Queue pointers, occupancy, and the registered arready/busy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      q_cnt_r   <= '0;
      arready_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      q_cnt_r   <= q_cnt_nxt_s;
      arready_r <= (q_cnt_nxt_s != CNT_FULL);
      busy_r    <= (q_cnt_nxt_s != '0) | (state_nxt_s == ST_BURST);
    end
  end

  // R engine: load or advance the beat and register the full R payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cur_id_r    <= '0;
      cur_len_r   <= '0;
      cur_size_r  <= '0;
      cur_mode_r  <= BURST_FIXED;
      cur_err_r   <= 1'b0;
      beat_addr_r <= '0;
      beat_cnt_r  <= '0;
      rvalid_r    <= 1'b0;
      rlast_r     <= 1'b0;
      rid_r       <= '0;
      rdata_r     <= '0;
      rresp_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (pop_s || adv_s) begin
        cur_id_r    <= src_id_s;
        cur_len_r   <= src_len_s;
        cur_size_r  <= src_size_s;
        cur_mode_r  <= src_mode_s;
        cur_err_r   <= src_err_s;
        beat_addr_r <= src_addr_s;
        beat_cnt_r  <= src_cnt_s;
        rvalid_r    <= 1'b1;
        rlast_r     <= (src_cnt_s == src_len_s);
        rid_r       <= src_id_s;
        rdata_r     <= data_s;
        rresp_r     <= resp_s;
      end else if (go_idle_s) begin
        rvalid_r <= 1'b0;
        rlast_r  <= 1'b0;
        rid_r    <= '0;
        rdata_r  <= '0;
        rresp_r  <= '0;
      end
    end
  end

  assign axi_slv_arready = arready_r;
  assign axi_slv_rvalid  = rvalid_r;
  assign axi_slv_rid     = rid_r;
  assign axi_slv_rdata   = rdata_r;
  assign axi_slv_rresp   = rresp_r;
  assign axi_slv_rlast   = rlast_r;
  assign slv_busy        = busy_r;

endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// Directed bench for easyaxi_slv_rd: ordering, address walks, capacity, stalls, errors, reset.
module tb_easyaxi_slv_rd;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arvalid = 1'b0, arready;
  logic [3:0]  arid = 4'd0;
  logic [31:0] araddr = 32'd0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'd0;
  logic [1:0]  arburst = 2'd0;
  logic        rvalid, rready = 1'b1, rlast, busy;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int ncmp = 0;
  int nerr = 0;
  int gap;
  logic [31:0] exp_d [16];
  logic [1:0]  exp_r [16];

  easyaxi_slv_rd #(.OST_DEPTH(8), .MEM_BYTES('h1000)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_slv_arvalid(arvalid), .axi_slv_arready(arready), .axi_slv_arid(arid),
    .axi_slv_araddr(araddr), .axi_slv_arlen(arlen), .axi_slv_arsize(arsize),
    .axi_slv_arburst(arburst), .axi_slv_rvalid(rvalid), .axi_slv_rready(rready),
    .axi_slv_rid(rid), .axi_slv_rdata(rdata), .axi_slv_rresp(rresp),
    .axi_slv_rlast(rlast), .slv_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int w;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    w = 0;
    while (!arready && w < 50) begin @(negedge clk); w++; end
    chk("ar_accept", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic set_incr(input logic [31:0] base, input int n, input logic [1:0] resp);
    for (int i = 0; i < n; i++) begin
      exp_d[i] = (resp == 2'b00) ? base + 32'(4 * i) : 32'd0;
      exp_r[i] = resp;
    end
  endtask

  // Collects n beats with rready held high; gap is the wait before the first beat.
  task automatic rx_burst(input string tag, input logic [3:0] id, input int n);
    int w;
    w = 0;
    while (!rvalid && w < 20) begin @(negedge clk); w++; end
    gap = w;
    chk({tag, "_valid"}, rvalid, 1);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, rdata, exp_d[i]);
      chk({tag, "_resp"}, rresp, exp_r[i]);
      chk({tag, "_last"}, rlast, (i == n - 1) ? 1 : 0);
      chk({tag, "_id"}, rid, id);
      @(negedge clk);
    end
  endtask

  initial begin
    int acc, b, stale;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1 chk("rel_arready_low", arready, 0);
    @(negedge clk);
    chk("rel_arready_high", arready, 1);

    // 1: INCR latency and data
    send_ar(4'd1, 32'h10, 8'd3, 3'd2, 2'b01);
    chk("lat_k1_rvalid", rvalid, 0);
    @(negedge clk);
    chk("lat_k2_rvalid", rvalid, 1);
    set_incr(32'h10, 4, 2'b00);
    rx_burst("incr", 4'd1, 4);
    chk("incr_idle_rvalid", rvalid, 0);
    chk("incr_idle_busy", busy, 0);

    // 2: WRAP and FIXED walks
    send_ar(4'd2, 32'h34, 8'd3, 3'd2, 2'b10);
    exp_d[0] = 32'h34; exp_d[1] = 32'h38; exp_d[2] = 32'h3C; exp_d[3] = 32'h30;
    for (int i = 0; i < 4; i++) exp_r[i] = 2'b00;
    rx_burst("wrap", 4'd2, 4);
    send_ar(4'd3, 32'h40, 8'd3, 3'd2, 2'b00);
    for (int i = 0; i < 4; i++) exp_d[i] = 32'h40;
    rx_burst("fixed", 4'd3, 4);

    // 3: capacity of 9 with rready low, then ordered gapless drain
    rready = 1'b0;
    acc = 0;
    arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    for (int c = 0; c < 40 && acc < 16; c++) begin
      arid = 4'(acc);
      araddr = 32'h100 + 32'(acc * 16);
      if (arready) acc++;
      @(negedge clk);
    end
    arvalid = 1'b0;
    chk("cap_accepted", 32'(acc), 9);
    chk("cap_arready", arready, 0);
    chk("cap_busy", busy, 1);
    rready = 1'b1;
    for (int id = 0; id < 9; id++) begin
      set_incr(32'h100 + 32'(id * 16), 4, 2'b00);
      rx_burst("order", 4'(id), 4);
      chk("order_gap", 32'(gap), 0);
    end
    chk("drain_rvalid", rvalid, 0);
    chk("drain_arready", arready, 1);

    // 4: random rready stalls keep the payload stable
    rready = 1'b0;
    send_ar(4'd2, 32'h200, 8'd7, 3'd2, 2'b01);
    b = 0;
    for (int c = 0; c < 200 && b < 8; c++) begin
      if (rvalid) begin
        chk("stall_data", rdata, 32'h200 + 32'(4 * b));
        chk("stall_last", rlast, (b == 7) ? 1 : 0);
        chk("stall_id", rid, 2);
      end
      rready = 1'($urandom_range(0, 1));
      if (rvalid && rready) b++;
      @(negedge clk);
    end
    chk("stall_beats", 32'(b), 8);
    chk("stall_end_rvalid", rvalid, 0);
    rready = 1'b1;

    // 5: DECERR at the range end and SLVERR cases
    send_ar(4'd4, 32'hFFC, 8'd1, 3'd2, 2'b01);
    exp_d[0] = 32'hFFC; exp_r[0] = 2'b00;
    exp_d[1] = 32'h0;   exp_r[1] = 2'b11;
    rx_burst("decerr", 4'd4, 2);
    send_ar(4'd5, 32'h20, 8'd2, 3'd2, 2'b10);
    set_incr(32'h0, 3, 2'b10);
    rx_burst("wrap_len2", 4'd5, 3);
    send_ar(4'd6, 32'h40, 8'd0, 3'd3, 2'b01);
    set_incr(32'h0, 1, 2'b10);
    rx_burst("size3", 4'd6, 1);
    send_ar(4'd7, 32'h50, 8'd1, 3'd2, 2'b11);
    set_incr(32'h0, 2, 2'b10);
    rx_burst("rsv_burst", 4'd7, 2);

    // 6: reset in the middle of a burst
    send_ar(4'd3, 32'h300, 8'd7, 3'd2, 2'b01);
    @(negedge clk);
    chk("mid_beat0", rdata, 32'h300);
    @(negedge clk);
    chk("mid_beat1", rdata, 32'h304);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_arready", arready, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_arready", arready, 1);
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      if (rvalid) stale++;
      @(negedge clk);
    end
    chk("mid_no_stale", 32'(stale), 0);
    send_ar(4'd5, 32'h500, 8'd0, 3'd2, 2'b01);
    set_incr(32'h500, 1, 2'b00);
    rx_burst("post_rst", 4'd5, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
